// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared constants and helpers for the FIFO write-port arbiter.
//   - FIFO fill-status codes as reported by the Sync FIFO (fifo_status).
//   - Arbiter FSM state encoding (one-hot, 3 bits).
//   - Small helpers that classify a fifo_status value.
//   No ports (package).
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    // FIFO fill-status codes
    localparam logic [2:0] FIFO_ST_EMPTY = 3'd0;  // completely empty
    localparam logic [2:0] FIFO_ST_Q0    = 3'd4;  // 0/4 empty (almost full)
    localparam logic [2:0] FIFO_ST_FULL  = 3'd5;  // full
    localparam logic [2:0] BURST_MAX_ST  = 3'd3;  // at least 1/4 free

    // Arbiter FSM states (one-hot)
    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_WRITE  = 3'b010;
    localparam logic [2:0] ST_SETTLE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WRITE  = ST_WRITE,
        S_SETTLE = ST_SETTLE
    } arb_state_t;

    // Codes 6 and 7 are not produced by the FIFO; treat them as full so a
    // corrupted status can never cause an overflow write.
    function automatic logic fifo_is_full(input logic [2:0] st);
        return (st >= FIFO_ST_FULL);
    endfunction

    // True when there is at least a quarter of the FIFO free.
    function automatic logic fifo_burst_room(input logic [2:0] st);
        return (st <= BURST_MAX_ST);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority encoder. The search starts at the index
//   after i_ptr and wraps explicitly at NUM_REQ-1, so NUM_REQ does not have
//   to be a power of two.
//
//   Ports:
//     i_req     [NUM_REQ-1:0]  request vector
//     i_ptr     [PTR_W-1:0]    index of the most recently served requester
//     o_any                    at least one request is present
//     o_idx     [PTR_W-1:0]    winning index (0 when o_any is low)
//     o_onehot  [NUM_REQ-1:0]  one-hot winner (0 when o_any is low)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [PTR_W-1:0]   o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);

    // (p + k) mod NUM_REQ for 1 <= k <= NUM_REQ, with an explicit wrap.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        // k = NUM_REQ revisits i_ptr itself last, so a lone requester that
        // was just served can still win.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!o_any && i_req[wrap_add(i_ptr, k)]) begin
                o_any = 1'b1;
                o_idx = wrap_add(i_ptr, k);
            end
        end
        if (o_any)
            o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the Sync FIFO write port among NUM_REQ
//   requesters. Every accepted word produces a one-cycle wr_en with a
//   coincident one-hot grant back to the winning requester. All outputs are
//   registered.
//
//   Base sequencing is IDLE -> WRITE -> SETTLE -> IDLE (1 word / 3 cycles).
//   SETTLE exists because fifo_status reflects our registered wr_en one
//   cycle late; deciding again before then could overflow the FIFO.
//
//   Optional build macro FIFO_WR_ARB_BURST_EN: when defined, a new winner
//   may be chosen directly from WRITE if the FIFO still has at least a
//   quarter free (status <= 3), giving back-to-back writes at 1 word/cycle.
//
//   Ports:
//     clk          clock
//     rst          asynchronous active-high reset
//     req          [NUM_REQ-1:0]        per-requester write request
//     req_data     [NUM_REQ*DATA_W-1:0] requester i at [i*DATA_W +: DATA_W]
//     fifo_status  [2:0]                FIFO fill status (5..7 = full)
//     grant        [NUM_REQ-1:0]        one-hot acceptance pulse
//     write_data   [DATA_W-1:0]         data to FIFO
//     wr_en                             FIFO write strobe
//     busy                              FSM not in IDLE
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [2:0]                fifo_status,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         write_data,
    output logic                      wr_en,
    output logic                      busy
);

    import fifo_arb_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [DATA_W-1:0]   r_data;
    logic                r_wr_en;
    logic                r_busy;

    logic                w_any;
    logic [PTR_W-1:0]    w_idx;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_issue_idle;
    logic                w_issue_burst;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_sel_data   = req_data[w_idx*DATA_W +: DATA_W];

    // Decision from IDLE: any request and the FIFO is not full.
    assign w_issue_idle = w_any && !fifo_is_full(fifo_status);

`ifdef FIFO_WR_ARB_BURST_EN
    // Chain straight from WRITE while a quarter of the FIFO is still free;
    // the status seen here lags by one word, which the quarter margin covers.
    assign w_issue_burst = w_any && fifo_burst_room(fifo_status);
`else
    assign w_issue_burst = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= PTR_W'(NUM_REQ - 1);  // requester 0 served first
            r_grant <= '0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a new grant is issued below.
            r_wr_en <= 1'b0;
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue_idle) begin
                        r_wr_en <= 1'b1;
                        r_grant <= w_onehot;
                        r_data  <= w_sel_data;
                        r_ptr   <= w_idx;
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_issue_burst) begin
                        r_wr_en <= 1'b1;
                        r_grant <= w_onehot;
                        r_data  <= w_sel_data;
                        r_ptr   <= w_idx;
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_SETTLE;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    // Dead cycle: fifo_status now includes the last write.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign write_data = r_data;
    assign wr_en      = r_wr_en;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Requesters are modelled as per-requester word lists; a requester asserts
//   req while it has a word and retires that word after its grant. Each
//   cycle the driver computes the expected outputs for the next cycle from
//   the arbitration rules and pushes them into a scoreboard; a separate
//   monitor compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int CAP = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [2:0]        fifo_status;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     write_data;
    logic              wr_en;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .fifo_status (fifo_status),
        .grant       (grant),
        .write_data  (write_data),
        .wr_en       (wr_en),
        .busy        (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          wr_en;
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    typedef struct {
        int cyc;
        int idx;
    } pop_t;

    exp_t sb[$];
    pop_t pops[$];

    logic [DW-1:0] wbuf [NR][CAP];
    int            wcnt [NR];

    int       n_tests = 0;
    int       n_fail  = 0;
    int       m_last;
    int       m_wait;
    logic     m_decided;
    logic [2:0] tb_st;

    // ---------------- requester word lists ----------------
    task automatic push_word(input int i, input logic [DW-1:0] d);
        if (wcnt[i] < CAP) begin
            wbuf[i][wcnt[i]] = d;
            wcnt[i]++;
        end
    endtask

    task automatic pop_word(input int i);
        if (wcnt[i] > 0) begin
            for (int k = 0; k < CAP - 1; k++)
                wbuf[i][k] = wbuf[i][k+1];
            wcnt[i]--;
        end
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_wait counts cycles before the arbiter may decide again: a grant is
    // followed by its write cycle and one settle cycle.
    task automatic model_cycle();
        exp_t e;
        int   w;
        logic decide;
        e.cyc   = cyc + 1;
        e.wr_en = 1'b0;
        e.grant = '0;
        e.data  = '0;
        e.busy  = 1'b0;
        decide  = 1'b0;
        if (m_wait == 0) begin
            decide = (|req) && (fifo_status < 3'd5);
        end else begin
`ifdef FIFO_WR_ARB_BURST_EN
            if (m_wait == 2 && (|req) && fifo_status <= 3'd3)
                decide = 1'b1;
`endif
        end
        if (decide) begin
            w = m_last;
            do w = (w + 1) % NR; while (!req[w]);
            e.wr_en = 1'b1;
            e.grant = NR'(1) << w;
            e.data  = wbuf[w][0];
            e.busy  = 1'b1;
            m_last  = w;
            m_wait  = 2;
            pops.push_back('{cyc + 2, w});
        end else if (m_wait > 0) begin
            m_wait--;
            e.busy = (m_wait > 0);
        end
        m_decided = decide;
        sb.push_back(e);
    endtask

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic step();
        while (pops.size() > 0 && pops[0].cyc <= cyc) begin
            pop_word(pops[0].idx);
            void'(pops.pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            req[i] = (wcnt[i] > 0);
            req_data[i*DW +: DW] = (wcnt[i] > 0) ? wbuf[i][0] : '0;
        end
        fifo_status = tb_st;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        pops.delete();
        for (int i = 0; i < NR; i++) wcnt[i] = 0;
        req = '0;
        req_data = '0;
        tb_st = 3'd0;
        fifo_status = 3'd0;
        m_last = NR - 1;
        m_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset grant", DW'(grant), '0);
        chk("reset wr_en", DW'(wr_en), '0);
        chk("reset busy", DW'(busy), '0);
        chk("reset write_data", write_data, '0);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.cyc != cyc || wr_en !== e.wr_en || grant !== e.grant ||
                    busy !== e.busy || (e.wr_en && write_data !== e.data)) begin
                    n_fail++;
                    $display("FAIL cycle %0d outputs: got wr_en=%b grant=%b busy=%b data=%h, expected wr_en=%b grant=%b busy=%b data=%h (for cycle %0d)",
                             cyc, wr_en, grant, busy, write_data,
                             e.wr_en, e.grant, e.busy, e.data, e.cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        fifo_status = 3'd0;

        // single request, first grant latency and dead cycles
        do_reset();
        push_word(0, 32'hA5A5_0001);
        run(6);

        // all four requesting: strict rotation, 3 cycles apart
        do_reset();
        for (int i = 0; i < NR; i++) begin
            push_word(i, 32'h1000_0000 + 32'(i));
            push_word(i, 32'h2000_0000 + 32'(i));
        end
        run(3 * 2 * NR + 4);

        // full stall: no grant, pointer held, then release
        do_reset();
        push_word(1, 32'h0000_0B01);
        run(4);
        tb_st = 3'd5;
        push_word(2, 32'h0000_0C02);
        run(10);
        tb_st = 3'd7;
        run(3);
        tb_st = 3'd2;
        push_word(0, 32'h0000_0A00);
        run(8);

        // rotation skips idle requesters: 1, then 3, then 1
        do_reset();
        push_word(1, 32'h0000_1111);
        run(4);
        push_word(1, 32'h0000_1112);
        push_word(3, 32'h0000_3331);
        run(8);

        // async reset during the write cycle
        do_reset();
        push_word(2, 32'hDEAD_0002);
        guard = 0;
        m_decided = 1'b0;
        while (!m_decided && guard < 10) begin
            step();
            guard++;
        end
        chk("pre-reset wr_en", DW'(wr_en), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid-write reset wr_en", DW'(wr_en), '0);
        chk("mid-write reset grant", DW'(grant), '0);
        chk("mid-write reset busy", DW'(busy), '0);
        do_reset();
        push_word(0, 32'h0000_A000);
        push_word(1, 32'h0000_B000);
        run(8);
        do_reset();
        push_word(1, 32'h0000_B001);
        run(4);

`ifdef FIFO_WR_ARB_BURST_EN
        // back-to-back grants while there is room, SETTLE once status >= 4
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_word(0, 32'hB0_000000 + 32'(k));
            push_word(1, 32'hB1_000000 + 32'(k));
        end
        tb_st = 3'd1;
        run(4);
        tb_st = 3'd4;
        run(8);
`endif

        // randomized traffic and status
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0)
                    push_word(i, $urandom);
            if ($urandom_range(0, 9) < 7)
                tb_st = 3'($urandom_range(0, 4));
            else
                tb_st = 3'($urandom_range(5, 7));
            step();
        end

        @(negedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
